line_buffer_ctrl: RTL and testbench

- Sequencer for the 10-row line buffer used in the Gaussian-blur and detect-filter passes.
- Issues row reads to the image/blur SRAMs and drives buffer_mode, buffer_we and fill_zero.
- Provides bottom-of-image zero padding and presents each complete row window to the downstream filter with a valid/ready handshake.

---
 rtl/line_buffer_ctrl.sv | 137 +++++++++++++
 tb/tb_line_buffer_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencer: issues row reads to the image/blur SRAMs, drives the buffer
// shift/zero-fill controls and hands each complete row window to the filter.
module line_buffer_ctrl #(
    parameter int unsigned ROWS  = 480,
    parameter int unsigned ROW_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode_sel,
    output logic             busy,
    output logic             done,
    output logic             sram_rd_en,
    output logic [ROW_W-1:0] sram_rd_addr,
    output logic [2:0]       buffer_mode,
    output logic             buffer_we,
    output logic             fill_zero,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [ROW_W-1:0] row_idx,
    output logic             pad_bottom
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_DAT  = 3'd2;
    localparam logic [2:0] ST_PAD  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_GAUSS  = 3'd1;
    localparam logic [2:0] MODE_DETECT = 3'd2;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] LAST_PAD = ROW_W'(ROWS + 2);
    localparam logic [ROW_W-1:0] ONE      = ROW_W'(1);
    localparam logic [ROW_W-1:0] TWO      = ROW_W'(2);
    localparam logic [ROW_W-1:0] THREE    = ROW_W'(3);

    logic [2:0]       state_q, state_d;
    logic [ROW_W-1:0] step_q, step_d;
    logic             detect_q, detect_d;

    logic in_dat;
    logic in_pad;
    logic priming;
    logic push;

    assign in_dat = (state_q == ST_DAT);
    assign in_pad = (state_q == ST_PAD);

    // Until the buffer holds a full window, rows are pushed without a handshake.
    assign priming = detect_q ? (step_q < TWO) : (step_q < THREE);
    assign push    = (in_dat && (priming || row_ready)) || (in_pad && row_ready);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        detect_d = detect_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RD;
                    step_d   = '0;
                    detect_d = mode_sel;
                end
            end
            ST_RD: begin
                state_d = ST_DAT;
            end
            ST_DAT: begin
                if (push) begin
                    step_d = step_q + ONE;
                    if (step_q < LAST_ROW) begin
                        state_d = ST_RD;
                    end else if (detect_q) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (push) begin
                    step_d = step_q + ONE;
                    if (step_q == LAST_PAD) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            detect_q <= detect_d;
        end
    end

    always_comb begin
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_FIN);
        sram_rd_en   = (state_q == ST_RD);
        sram_rd_addr = sram_rd_en ? step_q : '0;
        buffer_mode  = MODE_IDLE;
        if (busy) begin
            buffer_mode = detect_q ? MODE_DETECT : MODE_GAUSS;
        end
        row_valid  = (in_dat && !priming) || in_pad;
        pad_bottom = in_pad;
        // Window centre trails the newest row by one (detect) or three (Gaussian).
        row_idx = '0;
        if (row_valid) begin
            row_idx = detect_q ? (step_q - ONE) : (step_q - THREE);
        end
        buffer_we = push;
        fill_zero = in_pad && row_ready;
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        (row_valid && !row_ready) |=> (row_valid && $stable(row_idx) && $stable(pad_bottom)));

    assert property (@(posedge clk) disable iff (!rst_n) !(buffer_we && sram_rd_en));

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Scoreboard bench for line_buffer_ctrl: per-job expectations are queued at issue time
// and a negedge monitor pops and compares them as the DUT presents reads/windows/done.
module tb_line_buffer_ctrl;

    localparam int ROWS  = 8;
    localparam int ROW_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             mode_sel;
    logic             busy;
    logic             done;
    logic             sram_rd_en;
    logic [ROW_W-1:0] sram_rd_addr;
    logic [2:0]       buffer_mode;
    logic             buffer_we;
    logic             fill_zero;
    logic             row_valid;
    logic             row_ready;
    logic [ROW_W-1:0] row_idx;
    logic             pad_bottom;

    line_buffer_ctrl #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode_sel     (mode_sel),
        .busy         (busy),
        .done         (done),
        .sram_rd_en   (sram_rd_en),
        .sram_rd_addr (sram_rd_addr),
        .buffer_mode  (buffer_mode),
        .buffer_we    (buffer_we),
        .fill_zero    (fill_zero),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_idx      (row_idx),
        .pad_bottom   (pad_bottom)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int pushes;
        int fills;
        int mode;
    } job_t;

    typedef struct {
        int idx;
        bit pad;
    } win_t;

    job_t job_q[$];
    win_t win_q[$];
    int   rd_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int job_start;
    int n_we;
    int n_fz;
    int rdy_policy;
    int stall_idx;
    int stall_left;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_en"}, sram_rd_en, 0);
        check({tag, "_rd_addr"}, sram_rd_addr, 0);
        check({tag, "_buffer_mode"}, buffer_mode, 0);
        check({tag, "_buffer_we"}, buffer_we, 0);
        check({tag, "_fill_zero"}, fill_zero, 0);
        check({tag, "_row_valid"}, row_valid, 0);
        check({tag, "_row_idx"}, row_idx, 0);
        check({tag, "_pad_bottom"}, pad_bottom, 0);
    endtask

    // Reference: every row is read once in order; Gaussian presents centres 0..ROWS-1 with
    // the last three padded, detect presents 1..ROWS-2. Each row costs a read cycle and a
    // push cycle, Gaussian adds three pad cycles, then one FIN cycle.
    task automatic expect_job(input int mode, input int extra);
        job_t j;
        job_start = 1 << 30;
        for (int r = 0; r < ROWS; r++) rd_q.push_back(r);
        if (mode == 0) begin
            for (int r = 0; r < ROWS; r++) win_q.push_back('{r, (r >= ROWS - 3)});
        end else begin
            for (int r = 1; r <= ROWS - 2; r++) win_q.push_back('{r, 1'b0});
        end
        j.mode   = mode;
        j.pushes = (mode == 0) ? ROWS + 3 : ROWS;
        j.fills  = (mode == 0) ? 3 : 0;
        j.len    = (extra < 0) ? -1 : ((mode == 0) ? 2 * ROWS + 4 : 2 * ROWS + 1) + extra;
        job_q.push_back(j);
    endtask

    task automatic flush_model();
        rd_q.delete();
        win_q.delete();
        job_q.delete();
        n_we      = 0;
        n_fz      = 0;
        job_start = 1 << 30;
    endtask

    task automatic run_job(input int mode, input int extra, input bit pulse);
        int n;
        expect_job(mode, extra);
        @(posedge clk); #1;
        mode_sel  = mode[0];
        start     = 1'b1;
        job_start = cyc;
        n = 0;
        while (job_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
            start = pulse && (job_q.size() != 0) && ($urandom_range(0, 2) == 0);
            if (pulse) mode_sel = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        if (job_q.size() != 0) begin
            check("job_timeout", job_q.size(), 0);
            flush_model();
        end
    endtask

    // Ready driver: always high, random, or held low for stall_left cycles on one window.
    initial begin
        row_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_policy)
                0: row_ready = 1'b1;
                1: row_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (stall_left > 0 && row_valid && int'(row_idx) == stall_idx) begin
                        row_ready = 1'b0;
                        stall_left--;
                    end else begin
                        row_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    logic prev_stall = 1'b0;
    int   prev_idx;
    logic prev_pad;
    int   exp_mode;
    bit   busy_exp;
    job_t jd;
    win_t wd;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", row_valid, 1);
                check("hold_idx", row_idx, prev_idx);
                check("hold_pad", pad_bottom, prev_pad);
            end
            if (row_valid && !row_ready) begin
                check("stall_buffer_we", buffer_we, 0);
                check("stall_rd_en", sram_rd_en, 0);
            end
            if (fill_zero) begin
                check("fill_zero_with_pad_push",
                      buffer_we && pad_bottom && row_valid && row_ready, 1);
            end

            busy_exp = (job_q.size() != 0) && (cyc > job_start);
            check("busy", busy, busy_exp);
            exp_mode = busy_exp ? job_q[0].mode + 1 : 0;
            check("buffer_mode", buffer_mode, exp_mode);

            if (sram_rd_en) begin
                if (rd_q.size() == 0) check("rd_unexpected", sram_rd_en, 0);
                else check("rd_addr", sram_rd_addr, rd_q.pop_front());
            end
            if (row_valid && row_ready) begin
                if (win_q.size() == 0) begin
                    check("window_unexpected", row_valid, 0);
                end else begin
                    wd = win_q.pop_front();
                    check("win_idx", row_idx, wd.idx);
                    check("win_pad", pad_bottom, wd.pad);
                end
            end
            n_we = n_we + int'(buffer_we);
            n_fz = n_fz + int'(fill_zero);

            if (done) begin
                if (job_q.size() == 0) begin
                    check("done_unexpected", done, 0);
                end else begin
                    jd = job_q.pop_front();
                    if (jd.len >= 0) check("done_cycle", cyc - job_start, jd.len);
                    check("push_count", n_we, jd.pushes);
                    check("fill_count", n_fz, jd.fills);
                    check("reads_left", rd_q.size(), 0);
                    check("windows_left", win_q.size(), 0);
                    n_we = 0;
                    n_fz = 0;
                    job_start = 1 << 30;
                end
            end

            prev_stall <= row_valid && !row_ready;
            prev_idx   <= int'(row_idx);
            prev_pad   <= pad_bottom;
        end
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        mode_sel   = 1'b0;
        rdy_policy = 0;
        stall_idx  = 0;
        stall_left = 0;
        n_we       = 0;
        n_fz       = 0;
        job_start  = 1 << 30;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        run_job(0, 0, 1'b0);
        run_job(1, 0, 1'b0);

        rdy_policy = 2;
        stall_idx  = 0;
        stall_left = 5;
        run_job(0, 5, 1'b0);
        stall_idx  = 6;
        stall_left = 3;
        run_job(0, 3, 1'b0);
        rdy_policy = 0;

        run_job(0, 0, 1'b1);
        run_job(1, 0, 1'b1);

        // Abort a Gaussian job in DAT at step 4 (window centre 1).
        expect_job(0, 0);
        @(posedge clk); #1;
        mode_sel  = 1'b0;
        start     = 1'b1;
        job_start = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!(row_valid && row_idx == 4'd1) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("abort_reached", row_valid && row_idx == 4'd1, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("abort");
        check("abort_no_done", job_q.size(), 1);
        flush_model();
        rst_n = 1'b1;
        run_job(0, 0, 1'b0);

        rdy_policy = 1;
        repeat (20) run_job(int'($urandom_range(0, 1)), -1, 1'b1);
        rdy_policy = 0;
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
